// File: rtl/acu_pkg.sv
// Shared op and FSM state encodings for the accumulator arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package acu_pkg;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_READ = 2'b11
    } acu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_e;

endpackage

// File: rtl/acu_arbiter_ctrl_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; grant is recomputed every cycle from req.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/acu_arbiter_ctrl.sv
// Shares one external accumulator among NREQ requesters with round-robin arbitration.
// Latency: accept at T, accumulator write at T+1, response valid from T+2.
// Backpressure: response held until resp_ready; no new accept while busy.
module acu_arbiter_ctrl
    import acu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*2-1:0]     req_op,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic [WIDTH-1:0]      acu_q,
    output logic [WIDTH-1:0]      acu_d,
    output logic                  acu_ce,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [IDW-1:0]        resp_id,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  resp_ovf,
    output logic                  busy
);

    typedef struct packed {
        acu_op_e          op;
        logic [WIDTH-1:0] data;
        logic [IDW-1:0]   id;
    } txn_t;

    state_e           state;
    state_e           state_nxt;
    txn_t             txn_q;
    logic [IDW-1:0]   rr_ptr;
    logic             ovf_q;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_idx;
    logic             accept;
    logic             resp_hs;

    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   dif_ext;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign accept  = (state == S_IDLE) && (|req_valid);
    assign resp_hs = (state == S_RESP) && resp_ready;

    // Borrow falls out as the top bit of the widened subtraction.
    assign sum_ext = {1'b0, acu_q} + {1'b0, txn_q.data};
    assign dif_ext = {1'b0, acu_q} - {1'b0, txn_q.data};

    always_comb begin
        alu_res = acu_q;
        alu_ovf = 1'b0;
        case (txn_q.op)
            OP_LOAD: alu_res = txn_q.data;
            OP_ADD:  {alu_ovf, alu_res} = sum_ext;
            OP_SUB:  {alu_ovf, alu_res} = dif_ext;
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (|req_valid) state_nxt = S_EXEC;
            S_EXEC: state_nxt = S_RESP;
            S_RESP: if (resp_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            txn_q  <= '0;
            rr_ptr <= '0;
            ovf_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                txn_q.op   <= acu_op_e'(req_op[2*int'(grant_idx) +: 2]);
                txn_q.data <= req_data[WIDTH*int'(grant_idx) +: WIDTH];
                txn_q.id   <= grant_idx;
            end
            if (state == S_EXEC) begin
                ovf_q <= alu_ovf;
            end
            // Pointer moves past the served requester so it ranks last next time.
            if (resp_hs) begin
                rr_ptr <= (txn_q.id == IDW'(NREQ-1)) ? '0 : txn_q.id + IDW'(1);
            end
        end
    end

    // rst gate keeps the combinational strobe low while reset is held.
    assign req_ready  = (accept && !rst) ? grant : '0;
    assign acu_ce     = (state == S_EXEC) && (txn_q.op != OP_READ);
    assign acu_d      = (state == S_EXEC) ? alu_res : '0;
    assign resp_valid = (state == S_RESP);
    assign resp_data  = resp_valid ? acu_q : '0;
    assign resp_id    = resp_valid ? txn_q.id : '0;
    assign resp_ovf   = resp_valid & ovf_q;
    assign busy       = (state != S_IDLE);

endmodule
